store_write_buffer: RTL and testbench
=====================================

# store_write_buffer

Write buffer downstream of the store data queue. It accepts committed stores issued from the SDQ head, holds them in a small in-order FIFO, and drains them one at a time to the data memory port using a req/gnt handshake. Loads can forward from any store still in the buffer, including one arriving in the same cycle, so a load never misses data that has left the SDQ but has not yet reached memory.

## Interface
Parameters:
- WB_ENTRIES, default 4: buffer depth. Must be a power of two and at least 2.

Ports:
- clk_i  in  1  clock; every register updates on the rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- wr_vld_i  in  1  store issued by the SDQ (driven from the SDQ issue_vld).
- wr_addr_i  in  32  store word address.
- wr_data_i  in  32  store data.
- wb_ready_o  out  1  high when at least 2 entries are free; the SDQ issues only while this is high.
- wb_empty_o  out  1  buffer holds no entries.
- overflow_o  out  1  sticky error flag: a write arrived while the buffer was full.
- mem_req_o  out  1  memory write request.
- mem_addr_o  out  32  address of the head entry.
- mem_data_o  out  32  data of the head entry.
- mem_gnt_i  in  1  memory accepts the request in this cycle.
- ld_vld_i  in  1  load lookup is valid.
- ld_addr_i  in  32  load address.
- ld_hit_o  out  1  the load matched a buffered or incoming store.
- ld_data_o  out  32  data from the youngest matching store.

## Operation
- Storage: circular FIFO of WB_ENTRIES entries, each {valid, addr, data}.
  - head_ptr and tail_ptr are log2(WB_ENTRIES)+1 bits wide and use the extra wrap bit.
  - count = tail_ptr - head_ptr, modulo 2^(log2(WB_ENTRIES)+1).
  - full when the index bits are equal and the wrap bits differ; empty when the two pointers are equal.
- Write: when wr_vld_i is high and the buffer is not full, store {addr, data} at tail, set valid, and increment tail.
  - When wr_vld_i is high and the buffer is full, drop the write and set overflow_o. It stays set until reset.
- wb_ready_o = (count <= WB_ENTRIES-2). The two-entry slack covers the SDQ's registered issue.
- Drain FSM, two states:
  - IDLE: mem_req_o=0. Go to REQ when the buffer is non-empty.
  - REQ: mem_req_o=1; mem_addr_o and mem_data_o show the head entry and must stay stable until gnt.
  - In REQ with mem_gnt_i=1: clear the head valid bit and increment head. Stay in REQ if count after the retire is nonzero, otherwise go to IDLE.
  - In REQ with mem_gnt_i=0: hold all state.
- Stores drain strictly in FIFO order, and the buffer never merges or reorders them.
- Forwarding is combinational and active only when ld_vld_i=1.
  - Candidates, oldest to youngest: every valid entry from head toward tail, then the incoming write when wr_vld_i=1 and the buffer is not full.
  - The youngest candidate whose address equals ld_addr_i wins. It sets ld_hit_o=1 and drives its data on ld_data_o.
  - The entry being retired this cycle is still a candidate.
  - If nothing matches, ld_hit_o=0 and ld_data_o=0.
- Simultaneous write and retire: both occur, count is unchanged, and both pointers advance.

## Timing
- Reset values: pointers 0, all valid bits 0, FSM in IDLE.
  - mem_req_o=0, mem_addr_o=0, mem_data_o=0.
  - wb_ready_o=1, wb_empty_o=1, overflow_o=0, ld_hit_o=0, ld_data_o=0.
- Assertion of rst_ni low takes effect immediately and asynchronously.
  - Reset mid-drain discards all entries and drops mem_req_o at once.
- Write-to-request latency: a write captured at edge N gives count=1 after N. The FSM enters REQ at edge N+1, so mem_req_o is high in the cycle after N+1.
- Back-to-back drain: if gnt arrives in cycle k and another entry remains, mem_req_o stays high. The next entry's addr and data are presented in cycle k+1, giving one store per cycle under continuous gnt.
- Forwarding has zero latency: ld_hit_o and ld_data_o are valid in the same cycle as ld_vld_i.
- wb_empty_o and wb_ready_o are derived from registered pointers only, with no combinational path from wr_vld_i.
- Pointer wrap: indices wrap modulo WB_ENTRIES and the wrap bit toggles. Full and empty detection must stay correct across any number of wraps.

## Test plan
- Single store: write addr 0x100, data 0xDEADBEEF, with mem_gnt_i tied high.
  - Required: mem_req_o rises 2 cycles after the write with addr 0x100 and data 0xDEADBEEF, is high for exactly 1 cycle, and wb_empty_o returns to 1.
- Fill and backpressure (WB_ENTRIES=4): write 4 stores with mem_gnt_i=0.
  - Required: wb_ready_o falls once count reaches 3, and a 5th write sets overflow_o=1 while leaving the contents unchanged.
  - Then release gnt. Required: the 4 stores drain in order on 4 consecutive cycles.
- Forwarding priority: buffer 0x40 to 0x11, then 0x40 to 0x22; load 0x40.
  - Required: hit with 0x22.
  - Then drive a same-cycle write of 0x40 to 0x33 while loading 0x40. Required: hit with 0x33.
  - Load 0x44. Required: ld_hit_o=0 and ld_data_o=0.
- Stalled handshake: hold gnt low for 5 cycles during REQ, then assert it for 1 cycle.
  - Required: addr and data stay stable throughout, exactly one retire occurs, and a load to the head address still hits during the gnt cycle.
- Wrap-around: stream 20 stores with gnt toggling every cycle and writes issued only while wb_ready_o is high.
  - Required: all 20 appear on the memory port in order with no overflow, and empty and full stay consistent across pointer wraps.
- Async reset: assert rst_ni low mid-drain between clock edges.
  - Required: mem_req_o=0 and wb_empty_o=1 immediately.
  - Required: after release, a new write drains normally and no stale entries appear.

Source files
------------

// File: rtl/store_write_buffer_if.sv
// Store write buffer bus bundle: SDQ write port, memory drain port and load-forward lookup.
interface store_write_buffer_if;
    logic        wr_vld_i;
    logic [31:0] wr_addr_i;
    logic [31:0] wr_data_i;
    logic        wb_ready_o;
    logic        wb_empty_o;
    logic        overflow_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_gnt_i;
    logic        ld_vld_i;
    logic [31:0] ld_addr_i;
    logic        ld_hit_o;
    logic [31:0] ld_data_o;

    // The buffer itself
    modport slave (
        input  wr_vld_i, wr_addr_i, wr_data_i, mem_gnt_i, ld_vld_i, ld_addr_i,
        output wb_ready_o, wb_empty_o, overflow_o, mem_req_o, mem_addr_o, mem_data_o,
               ld_hit_o, ld_data_o
    );

    // SDQ / memory / load-unit side
    modport master (
        output wr_vld_i, wr_addr_i, wr_data_i, mem_gnt_i, ld_vld_i, ld_addr_i,
        input  wb_ready_o, wb_empty_o, overflow_o, mem_req_o, mem_addr_o, mem_data_o,
               ld_hit_o, ld_data_o
    );
endinterface

// File: rtl/store_write_buffer.sv
// In-order store write buffer: captures committed stores, drains them over req/gnt,
// and forwards data to loads from any buffered or same-cycle incoming store.
module store_write_buffer #(
    parameter int unsigned WB_ENTRIES = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    store_write_buffer_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(WB_ENTRIES);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    typedef enum logic {IDLE, REQ} state_t;

    entry_t             ent_q [WB_ENTRIES];
    logic [PTR_W-1:0]   head_ptr;
    logic [PTR_W-1:0]   tail_ptr;
    logic [PTR_W-1:0]   count;
    logic [IDX_W-1:0]   head_idx;
    logic [IDX_W-1:0]   tail_idx;
    logic [IDX_W-1:0]   next_idx;
    logic [IDX_W-1:0]   fwd_idx;
    logic               full;
    logic               empty;
    logic               wr_fire;
    logic               retire;
    logic               overflow_q;
    state_t             state;
    logic               mem_req_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_data_q;
    logic               ld_hit;
    logic [31:0]        ld_data;

    assign head_idx = head_ptr[IDX_W-1:0];
    assign tail_idx = tail_ptr[IDX_W-1:0];
    assign next_idx = head_idx + IDX_W'(1);
    assign count    = tail_ptr - head_ptr;
    assign full     = (head_idx == tail_idx) && (head_ptr[IDX_W] != tail_ptr[IDX_W]);
    assign empty    = (head_ptr == tail_ptr);
    assign wr_fire  = bus.wr_vld_i && !full;
    assign retire   = (state == REQ) && bus.mem_gnt_i;

    // Entry storage, pointers and sticky overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(WB_ENTRIES); i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            if (retire) begin
                ent_q[head_idx].valid <= 1'b0;
                head_ptr              <= head_ptr + PTR_W'(1);
            end
            if (wr_fire) begin
                ent_q[tail_idx] <= '{valid: 1'b1, addr: bus.wr_addr_i, data: bus.wr_data_i};
                tail_ptr        <= tail_ptr + PTR_W'(1);
            end
            if (bus.wr_vld_i && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Drain FSM; the next head is preloaded on gnt so back-to-back stores go out every cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state      <= REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= ent_q[head_idx].addr;
                        mem_data_q <= ent_q[head_idx].data;
                    end
                end
                REQ: begin
                    if (bus.mem_gnt_i) begin
                        if (count > PTR_W'(1)) begin
                            mem_addr_q <= ent_q[next_idx].addr;
                            mem_data_q <= ent_q[next_idx].data;
                        end else if (wr_fire) begin
                            // Sole entry retiring while a new store lands right behind it
                            mem_addr_q <= bus.wr_addr_i;
                            mem_data_q <= bus.wr_data_i;
                        end else begin
                            state     <= IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Load forwarding: scan oldest to youngest so the last match wins
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwd_idx = head_idx;
        if (bus.ld_vld_i) begin
            for (int unsigned i = 0; i < WB_ENTRIES; i++) begin
                fwd_idx = head_idx + IDX_W'(i);
                if ((PTR_W'(i) < count) && ent_q[fwd_idx].valid &&
                    (ent_q[fwd_idx].addr == bus.ld_addr_i)) begin
                    ld_hit  = 1'b1;
                    ld_data = ent_q[fwd_idx].data;
                end
            end
            if (wr_fire && (bus.wr_addr_i == bus.ld_addr_i)) begin
                ld_hit  = 1'b1;
                ld_data = bus.wr_data_i;
            end
        end
    end

    assign bus.wb_ready_o = (count <= PTR_W'(WB_ENTRIES - 2));
    assign bus.wb_empty_o = empty;
    assign bus.overflow_o = overflow_q;
    assign bus.mem_req_o  = mem_req_q;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.mem_data_o = mem_data_q;
    assign bus.ld_hit_o   = ld_hit;
    assign bus.ld_data_o  = ld_data;

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer with a FIFO scoreboard on the memory drain port.
module tb_store_write_buffer;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } st_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   drains      = 0;
    st_t  sb[$];

    store_write_buffer_if bus();

    store_write_buffer #(.WB_ENTRIES(4)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wr_vld_i  = 1'b0;
        bus.wr_addr_i = '0;
        bus.wr_data_i = '0;
        bus.mem_gnt_i = 1'b0;
        bus.ld_vld_i  = 1'b0;
        bus.ld_addr_i = '0;
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d);
        bus.wr_vld_i  = 1'b1;
        bus.wr_addr_i = a;
        bus.wr_data_i = d;
        sb.push_back({a, d});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!bus.mem_req_o && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(bus.mem_req_o), 32'd1);
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (!bus.wb_empty_o && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(bus.wb_empty_o), 32'd1);
    endtask

    // Drain monitor: every accepted request must match the oldest expected store
    always @(negedge clk) begin
        st_t e;
        #2;
        if (rst_n && bus.mem_req_o && bus.mem_gnt_i) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL drain_unexpected: observed addr 0x%08h expected no request",
                       bus.mem_addr_o);
            end else begin
                e = sb.pop_front();
                chk("drain_addr", bus.mem_addr_o, e.a);
                chk("drain_data", bus.mem_data_o, e.d);
            end
            drains++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int sent;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",     32'(bus.mem_req_o),  32'd0);
        chk("rst_addr",    bus.mem_addr_o,      32'd0);
        chk("rst_data",    bus.mem_data_o,      32'd0);
        chk("rst_ready",   32'(bus.wb_ready_o), 32'd1);
        chk("rst_empty",   32'(bus.wb_empty_o), 32'd1);
        chk("rst_ovf",     32'(bus.overflow_o), 32'd0);
        chk("rst_hit",     32'(bus.ld_hit_o),   32'd0);
        chk("rst_ld_data", bus.ld_data_o,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single store with gnt tied high
        @(negedge clk);
        bus.mem_gnt_i = 1'b1;
        push_write(32'h100, 32'hDEADBEEF);
        @(negedge clk);
        bus.wr_vld_i = 1'b0;
        #1;
        chk("t1_req_early", 32'(bus.mem_req_o),  32'd0);
        chk("t1_not_empty", 32'(bus.wb_empty_o), 32'd0);
        @(negedge clk);
        #1;
        chk("t1_req_on", 32'(bus.mem_req_o), 32'd1);
        chk("t1_addr",   bus.mem_addr_o,     32'h100);
        chk("t1_data",   bus.mem_data_o,     32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("t1_req_off", 32'(bus.mem_req_o),  32'd0);
        chk("t1_empty",   32'(bus.wb_empty_o), 32'd1);

        // Fill to full with gnt low, then overflow, then drain
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            push_write(32'h200 + 32'(i * 4), 32'h1000_0000 + 32'(i));
            #1;
            chk("t2_ready", 32'(bus.wb_ready_o), (i <= 2) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        bus.wr_vld_i  = 1'b1;
        bus.wr_addr_i = 32'h2FC;
        bus.wr_data_i = 32'h0000_0BAD;
        #1;
        chk("t2_ready_full", 32'(bus.wb_ready_o), 32'd0);
        chk("t2_ovf_pre",    32'(bus.overflow_o), 32'd0);
        @(negedge clk);
        bus.wr_vld_i  = 1'b0;
        bus.ld_vld_i  = 1'b1;
        bus.ld_addr_i = 32'h2FC;
        #1;
        chk("t2_ovf",        32'(bus.overflow_o), 32'd1);
        chk("t2_head_addr",  bus.mem_addr_o,      32'h200);
        chk("t2_drop_nohit", 32'(bus.ld_hit_o),   32'd0);
        bus.ld_addr_i = 32'h20C;
        #1;
        chk("t2_tail_hit",  32'(bus.ld_hit_o), 32'd1);
        chk("t2_tail_data", bus.ld_data_o,     32'h1000_0003);
        bus.ld_vld_i = 1'b0;
        d0 = drains;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.mem_gnt_i = 1'b1;
            #1;
            chk("t2_drain_req", 32'(bus.mem_req_o), 32'd1);
        end
        @(negedge clk);
        #1;
        chk("t2_req_done",  32'(bus.mem_req_o),  32'd0);
        chk("t2_empty",     32'(bus.wb_empty_o), 32'd1);
        chk("t2_ovf_stick", 32'(bus.overflow_o), 32'd1);
        chk("t2_drains",    32'(drains - d0),    32'd4);

        // Forwarding priority
        do_reset();
        @(negedge clk);
        push_write(32'h40, 32'h11);
        @(negedge clk);
        push_write(32'h40, 32'h22);
        @(negedge clk);
        bus.wr_vld_i  = 1'b0;
        bus.ld_vld_i  = 1'b1;
        bus.ld_addr_i = 32'h40;
        #1;
        chk("t3_hit_young",  32'(bus.ld_hit_o), 32'd1);
        chk("t3_data_young", bus.ld_data_o,     32'h22);
        @(negedge clk);
        push_write(32'h40, 32'h33);
        #1;
        chk("t3_hit_incoming",  32'(bus.ld_hit_o), 32'd1);
        chk("t3_data_incoming", bus.ld_data_o,     32'h33);
        @(negedge clk);
        bus.wr_vld_i  = 1'b0;
        bus.ld_addr_i = 32'h44;
        #1;
        chk("t3_miss_hit",  32'(bus.ld_hit_o), 32'd0);
        chk("t3_miss_data", bus.ld_data_o,     32'd0);
        @(negedge clk);
        bus.ld_vld_i  = 1'b0;
        bus.ld_addr_i = 32'h40;
        #1;
        chk("t3_ldvld_low", 32'(bus.ld_hit_o), 32'd0);
        bus.mem_gnt_i = 1'b1;
        wait_empty("t3_empty");
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Stalled handshake
        do_reset();
        @(negedge clk);
        push_write(32'h300, 32'hA5A5_0001);
        @(negedge clk);
        push_write(32'h304, 32'hA5A5_0002);
        @(negedge clk);
        bus.wr_vld_i = 1'b0;
        wait_req("t4_req");
        d0 = drains;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("t4_stall_req",  32'(bus.mem_req_o), 32'd1);
            chk("t4_stall_addr", bus.mem_addr_o,     32'h300);
            chk("t4_stall_data", bus.mem_data_o,     32'hA5A5_0001);
        end
        @(negedge clk);
        bus.mem_gnt_i = 1'b1;
        bus.ld_vld_i  = 1'b1;
        bus.ld_addr_i = 32'h300;
        #1;
        chk("t4_gnt_hit",  32'(bus.ld_hit_o), 32'd1);
        chk("t4_gnt_data", bus.ld_data_o,     32'hA5A5_0001);
        @(negedge clk);
        bus.mem_gnt_i = 1'b0;
        bus.ld_vld_i  = 1'b0;
        #1;
        chk("t4_one_retire", 32'(drains - d0),   32'd1);
        chk("t4_next_addr",  bus.mem_addr_o,     32'h304);
        chk("t4_next_req",   32'(bus.mem_req_o), 32'd1);
        bus.mem_gnt_i = 1'b1;
        wait_empty("t4_empty");

        // Wrap-around stream with toggling gnt
        do_reset();
        sent = 0;
        d0   = drains;
        for (int c = 0; c < 300 && (sent < 20 || sb.size() != 0); c++) begin
            @(negedge clk);
            chk("t5_empty", 32'(bus.wb_empty_o), 32'(sb.size() == 0));
            chk("t5_ready", 32'(bus.wb_ready_o), 32'(sb.size() <= 2));
            bus.mem_gnt_i = c[0];
            if (sent < 20 && bus.wb_ready_o) begin
                push_write(32'h1000 + 32'(sent * 4), $urandom);
                sent++;
            end else begin
                bus.wr_vld_i = 1'b0;
            end
        end
        bus.wr_vld_i  = 1'b0;
        bus.mem_gnt_i = 1'b0;
        #1;
        chk("t5_sent",   32'(sent),           32'd20);
        chk("t5_drains", 32'(drains - d0),    32'd20);
        chk("t5_ovf",    32'(bus.overflow_o), 32'd0);

        // Async reset mid-drain
        do_reset();
        @(negedge clk);
        push_write(32'h400, 32'h1);
        @(negedge clk);
        push_write(32'h404, 32'h2);
        @(negedge clk);
        bus.wr_vld_i = 1'b0;
        wait_req("t6_req");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req",   32'(bus.mem_req_o),  32'd0);
        chk("t6_rst_empty", 32'(bus.wb_empty_o), 32'd1);
        chk("t6_rst_ready", 32'(bus.wb_ready_o), 32'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        d0    = drains;
        @(negedge clk);
        bus.mem_gnt_i = 1'b1;
        push_write(32'h500, 32'h0BAD_F00D);
        @(negedge clk);
        bus.wr_vld_i = 1'b0;
        #1;
        wait_empty("t6_empty");
        repeat (3) @(negedge clk);
        #1;
        chk("t6_drains",  32'(drains - d0),    32'd1);
        chk("t6_no_req",  32'(bus.mem_req_o),  32'd0);
        chk("t6_sb_left", 32'(sb.size()),      32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
